gpr_wb_arbiter: RTL and testbench
=================================

Name: gpr_wb_arbiter

Overview:
Owns the single write port of the GPR file. Shares it between the pipeline W-stage writeback and a long-latency unit (LLU: mul/div). LLU results wait in a small FIFO, and a per-register scoreboard stalls decode on pending LLU destinations. Sits between the W stage, the LLU and the GPR write port, and drives a stall term into the hazard unit.

Parameters:
DEPTH, 4, LLU result FIFO entries (power of 2, >=2)
STARVE_LIMIT, 8, consecutive blocked cycles before starve is raised (>=1)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
wb_we  in  1  W-stage write enable
wb_addr  in  5  W-stage destination
wb_data  in  32  W-stage result (already jal-muxed)
issue_valid  in  1  LLU op issuing from D stage
issue_addr  in  5  LLU op destination
issue_ready  out  1  issue may proceed this cycle
llu_valid  in  1  LLU result available
llu_addr  in  5  LLU result destination
llu_data  in  32  LLU result value
llu_ready  out  1  FIFO accepts result this cycle
rs_addr  in  5  D-stage source A
rt_addr  in  5  D-stage source B
stall_d  out  1  D-stage must hold (RAW on pending LLU reg)
gpr_we  out  1  GPR write enable
gpr_waddr  out  5  GPR write address
gpr_wdata  out  32  GPR write data
starve  out  1  request that the hazard unit insert a W bubble
pending  out  32  scoreboard bits, for debug

Behaviour:
- Reset (async, rst_n=0): FIFO empty, pending=0, starve counter=0, starve=0. Combinational outputs then evaluate to gpr_we=0, llu_ready=1, issue_ready=1, stall_d=0. Results held in the FIFO or in flight are discarded.
- W priority: if wb_we=1 and wb_addr!=0, drive gpr_we=1, gpr_waddr=wb_addr, gpr_wdata=wb_data combinationally in the same cycle. The W stage is never blocked.
- Drain:
  - If W is not writing (wb_we=0 or wb_addr=0) and the FIFO is non-empty, pop the head.
  - The popped entry drives gpr_we=(head_addr!=0), gpr_waddr=head_addr, gpr_wdata=head_data.
  - At most one pop per cycle.
- Enqueue: llu_ready = !full. A push happens when llu_valid && llu_ready.
  - The FIFO is registered: a pushed result is poppable from the next cycle. Minimum latency is 1 cycle from acceptance to GPR write.
  - Push and pop in the same cycle are legal when full: llu_ready reflects the pre-pop full flag, so ready stays 0 when full.
  - Pointers wrap modulo DEPTH.
- Scoreboard:
  - Issue is accepted when issue_valid && issue_ready, where issue_ready = (issue_addr==0) || !pending[issue_addr].
  - On acceptance with issue_addr!=0, set pending[issue_addr] at the next edge. A second issue to a pending register (WAW) is held off.
  - On a pop with head_addr!=0, clear pending[head_addr] at the next edge.
  - Set and clear never target the same register in one cycle, because issue_ready forbids it.
- Effective pending: pend_eff = pending & ~commit_mask, where commit_mask is the one-hot of the address being popped this cycle.
  - stall_d = (rs_addr!=0 && pend_eff[rs_addr]) || (rt_addr!=0 && pend_eff[rt_addr]).
  - stall_d therefore falls in the commit cycle, and the GPR write-through forwards the value.
- Starvation counter:
  - Increments each cycle the FIFO is non-empty and W writes a nonzero register. Saturates at STARVE_LIMIT.
  - Clears on any pop, and whenever the FIFO is empty.
  - starve = (count==STARVE_LIMIT), registered. It holds until the next pop.
- A W write to a register whose pending bit is set is a hazard-unit bug. The arbiter does not check it; assertion only in the bench.
- Register 0: never written, never pending, never stalls.

Test Plan:
- Reset mid-drain: push 3 results, assert rst_n=0 for 1 cycle -> FIFO empty, pending=0, gpr_we=0, issue_ready=1.
- Idle W: issue to r5 (pending[5]=1), then llu_valid r5=0x1234 at cycle t -> gpr_we=1, waddr=5, wdata=0x1234 at t+1; stall_d on rs=5 high until t+1 and low at t+1; pending[5]=0 at t+2.
- W priority: FIFO holds r7; wb_we=1 r3=0xAA for 2 cycles -> GPR writes r3 on both cycles, r7 on the third cycle.
- Full: hold W busy and push DEPTH results -> llu_ready=0 after the 4th push; one idle W cycle -> pop plus llu_ready=1.
- WAW/r0: issue r9 twice -> second issue_ready=0 until r9 commits; issue/result to r0 -> accepted, popped, gpr_we=0, no pending bit.
- Starvation: FIFO non-empty, W writes r1 every cycle -> starve=1 after 8 cycles; one W bubble -> pop, starve=0 next cycle.

Source files
------------

// File: rtl/gpr_wb_arbiter.sv
// GPR write-port arbiter: W-stage writeback has priority, long-latency results drain from a FIFO
// in W's idle cycles, and a per-register scoreboard holds decode on pending LLU destinations.
module gpr_wb_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        issue_valid,
    input  logic [4:0]  issue_addr,
    output logic        issue_ready,
    input  logic        llu_valid,
    input  logic [4:0]  llu_addr,
    input  logic [31:0] llu_data,
    output logic        llu_ready,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic        stall_d,
    output logic        gpr_we,
    output logic [4:0]  gpr_waddr,
    output logic [31:0] gpr_wdata,
    output logic        starve,
    output logic [31:0] pending
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]  fifo_addr [DEPTH];
    logic [31:0] fifo_data [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic [CW-1:0] starve_cnt, cnt_nxt;

    logic        full, empty, push, pop, w_write, issue_acc;
    logic [4:0]  head_addr;
    logic [31:0] head_data;
    logic [31:0] set_mask, commit_mask, pend_eff, pending_nxt;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head_addr = fifo_addr[rd_ptr[AW-1:0]];
    assign head_data = fifo_data[rd_ptr[AW-1:0]];

    assign w_write   = wb_we && (wb_addr != 5'd0);
    assign pop       = !w_write && !empty;
    assign llu_ready = !full;
    assign push      = llu_valid && llu_ready;

    assign gpr_we    = w_write || (pop && (head_addr != 5'd0));
    assign gpr_waddr = w_write ? wb_addr : head_addr;
    assign gpr_wdata = w_write ? wb_data : head_data;

    assign issue_ready = (issue_addr == 5'd0) || !pending[issue_addr];
    assign issue_acc   = issue_valid && issue_ready;

    assign set_mask    = (issue_acc && (issue_addr != 5'd0)) ? (32'd1 << issue_addr) : 32'd0;
    assign commit_mask = (pop && (head_addr != 5'd0)) ? (32'd1 << head_addr) : 32'd0;
    assign pending_nxt = (pending | set_mask) & ~commit_mask;

    // The register committing this cycle is written through, so it no longer needs to stall.
    assign pend_eff = pending & ~commit_mask;
    assign stall_d  = ((rs_addr != 5'd0) && pend_eff[rs_addr]) ||
                      ((rt_addr != 5'd0) && pend_eff[rt_addr]);

    always_comb begin
        cnt_nxt = starve_cnt;
        if (empty || pop)
            cnt_nxt = '0;
        else if (w_write && (starve_cnt != CW'(STARVE_LIMIT)))
            cnt_nxt = starve_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr[AW-1:0]] <= llu_addr;
            fifo_data[wr_ptr[AW-1:0]] <= llu_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            pending    <= '0;
            starve_cnt <= '0;
            starve     <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            pending    <= pending_nxt;
            starve_cnt <= cnt_nxt;
            starve     <= (cnt_nxt == CW'(STARVE_LIMIT));
        end
    end
endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Bench for gpr_wb_arbiter: directed vector table, hand-written corner sequences, then
// randomized traffic checked against a queue-based model of the write-port rules.
module tb_gpr_wb_arbiter;
    localparam int DEPTH = 4;
    localparam int LIM   = 8;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        wb_we = 1'b0, issue_valid = 1'b0, llu_valid = 1'b0;
    logic [4:0]  wb_addr = '0, issue_addr = '0, llu_addr = '0, rs_addr = '0, rt_addr = '0;
    logic [31:0] wb_data = '0, llu_data = '0;
    logic        issue_ready, llu_ready, stall_d, gpr_we, starve;
    logic [4:0]  gpr_waddr;
    logic [31:0] gpr_wdata, pending;

    int checks = 0, errors = 0;

    gpr_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_ready(issue_ready),
        .llu_valid(llu_valid), .llu_addr(llu_addr), .llu_data(llu_data), .llu_ready(llu_ready),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .stall_d(stall_d),
        .gpr_we(gpr_we), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
        .starve(starve), .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;  logic [4:0] wa; logic [31:0] wd;
        logic        iv;  logic [4:0] ia;
        logic        lv;  logic [4:0] la; logic [31:0] ld;
        logic [4:0]  rs;  logic [4:0] rt;
        logic        e_we; logic [4:0] e_wa; logic [31:0] e_wd;
        logic        e_ir; logic e_lr; logic e_st; logic [31:0] e_pend;
    } vec_t;

    typedef struct { logic [4:0] a; logic [31:0] d; } ent_t;

    vec_t tbl [12];
    ent_t mq [$];
    logic [4:0] infl [$];
    logic [31:0] mpend;
    int mcnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic iv, input logic [4:0] ia,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld,
                       input logic [4:0] rs, input logic [4:0] rt);
        wb_we = we; wb_addr = wa; wb_data = wd;
        issue_valid = iv; issue_addr = ia;
        llu_valid = lv; llu_addr = la; llu_data = ld;
        rs_addr = rs; rt_addr = rt;
        #1;
    endtask

    task automatic idle();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    // A W write to a register still owned by the LLU would be a hazard-unit bug upstream.
    always @(negedge clk)
        if (rst_n && wb_we && wb_addr != 5'd0 && pending[wb_addr]) begin
            errors++;
            $display("FAIL w_to_pending: W wrote r%0d while pending=%0h", wb_addr, pending);
        end

    initial begin
        logic        we, iv, lv, wwr, mpop, e_we, e_ir, e_st;
        logic [4:0]  wa, ia, la, rs, rt;
        logic [31:0] wd, ld, mask, pe;
        ent_t        hd;
        int          wprob;

        //  we wa  wd        iv ia  lv la  ld        rs rt | e_we e_wa e_wd    ir lr st pend
        tbl[0]  = '{0, 0, 0,            1, 5, 0, 0, 0,             5, 0, 0, 0, 0,             1, 1, 0, 32'h0};
        tbl[1]  = '{0, 0, 0,            0, 5, 1, 5, 32'h1234,      5, 0, 0, 0, 0,             0, 1, 1, 32'h20};
        tbl[2]  = '{0, 0, 0,            0, 5, 0, 0, 0,             5, 0, 1, 5, 32'h1234,      0, 1, 0, 32'h20};
        tbl[3]  = '{0, 0, 0,            0, 5, 0, 0, 0,             5, 5, 0, 0, 0,             1, 1, 0, 32'h0};
        tbl[4]  = '{0, 0, 0,            0, 0, 1, 7, 32'h77,        0, 0, 0, 0, 0,             1, 1, 0, 32'h0};
        tbl[5]  = '{1, 3, 32'hAA,       0, 0, 0, 0, 0,             0, 0, 1, 3, 32'hAA,        1, 1, 0, 32'h0};
        tbl[6]  = '{1, 3, 32'hAA,       0, 0, 0, 0, 0,             0, 0, 1, 3, 32'hAA,        1, 1, 0, 32'h0};
        tbl[7]  = '{0, 0, 0,            0, 0, 0, 0, 0,             0, 0, 1, 7, 32'h77,        1, 1, 0, 32'h0};
        tbl[8]  = '{0, 0, 0,            0, 0, 1, 0, 32'h5,         0, 0, 0, 0, 0,             1, 1, 0, 32'h0};
        tbl[9]  = '{1, 0, 32'hDEAD,     0, 0, 0, 0, 0,             0, 0, 0, 0, 0,             1, 1, 0, 32'h0};
        tbl[10] = '{0, 0, 0,            1, 0, 0, 0, 0,             0, 0, 0, 0, 0,             1, 1, 0, 32'h0};
        tbl[11] = '{0, 0, 0,            0, 0, 0, 0, 0,             0, 0, 0, 0, 0,             1, 1, 0, 32'h0};

        // Reset state
        idle();
        #2;
        chk("rst_gpr_we", 32'(gpr_we), 0);
        chk("rst_llu_ready", 32'(llu_ready), 1);
        chk("rst_issue_ready", 32'(issue_ready), 1);
        chk("rst_pending", pending, 0);
        chk("rst_starve", 32'(starve), 0);
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 12; i++) begin
            drv(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].iv, tbl[i].ia,
                tbl[i].lv, tbl[i].la, tbl[i].ld, tbl[i].rs, tbl[i].rt);
            chk($sformatf("tbl%0d_we", i), 32'(gpr_we), 32'(tbl[i].e_we));
            if (tbl[i].e_we) begin
                chk($sformatf("tbl%0d_waddr", i), 32'(gpr_waddr), 32'(tbl[i].e_wa));
                chk($sformatf("tbl%0d_wdata", i), gpr_wdata, tbl[i].e_wd);
            end
            chk($sformatf("tbl%0d_issue_ready", i), 32'(issue_ready), 32'(tbl[i].e_ir));
            chk($sformatf("tbl%0d_llu_ready", i), 32'(llu_ready), 32'(tbl[i].e_lr));
            chk($sformatf("tbl%0d_stall", i), 32'(stall_d), 32'(tbl[i].e_st));
            chk($sformatf("tbl%0d_pending", i), pending, tbl[i].e_pend);
            chk($sformatf("tbl%0d_starve", i), 32'(starve), 0);
            tick();
        end

        // WAW hold-off on r9 until its result commits
        drv(0, 0, 0, 1, 9, 0, 0, 0, 0, 0);
        chk("waw_first_ready", 32'(issue_ready), 1);
        tick();
        drv(0, 0, 0, 1, 9, 0, 0, 0, 9, 0);
        chk("waw_second_ready", 32'(issue_ready), 0);
        chk("waw_stall", 32'(stall_d), 1);
        tick();
        drv(0, 0, 0, 1, 9, 1, 9, 32'h9999, 9, 0);
        chk("waw_ready_during_push", 32'(issue_ready), 0);
        tick();
        drv(0, 0, 0, 1, 9, 0, 0, 0, 0, 9);
        chk("waw_ready_commit", 32'(issue_ready), 0);
        chk("waw_commit_we", 32'(gpr_we), 1);
        chk("waw_commit_addr", 32'(gpr_waddr), 9);
        chk("waw_commit_data", gpr_wdata, 32'h9999);
        chk("waw_commit_stall", 32'(stall_d), 0);
        tick();
        drv(0, 0, 0, 1, 9, 1, 9, 32'h4242, 9, 0);
        chk("waw_reissue_ready", 32'(issue_ready), 1);
        tick();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
        chk("waw_reissue_pending", pending, 32'h200);
        tick();
        idle();
        chk("waw_final_pending", pending, 0);

        // Fill with W busy; llu_ready reflects pre-pop full
        for (int k = 0; k < DEPTH; k++) begin
            drv(1, 1, 32'h100 + 32'(k), 0, 0, 1, 5'(10 + k), 32'hA0 + 32'(k), 0, 0);
            chk($sformatf("full_ready_push%0d", k), 32'(llu_ready), 1);
            chk($sformatf("full_w_we%0d", k), 32'(gpr_waddr), 1);
            tick();
        end
        drv(1, 1, 32'h200, 0, 0, 1, 14, 32'hA4, 0, 0);
        chk("full_ready_low", 32'(llu_ready), 0);
        tick();
        drv(0, 0, 0, 0, 0, 1, 14, 32'hA4, 0, 0);
        chk("full_pop_we", 32'(gpr_we), 1);
        chk("full_pop_addr", 32'(gpr_waddr), 10);
        chk("full_pop_ready_still_low", 32'(llu_ready), 0);
        tick();
        chk("full_ready_after_pop", 32'(llu_ready), 1);
        chk("full_pop2_addr", 32'(gpr_waddr), 11);
        tick();
        for (int k = 0; k < 3; k++) begin
            idle();
            chk($sformatf("full_drain%0d_addr", k), 32'(gpr_waddr), 32'(12 + k));
            chk($sformatf("full_drain%0d_data", k), gpr_wdata, 32'hA2 + 32'(k));
            tick();
        end
        idle();
        chk("full_empty_we", 32'(gpr_we), 0);

        // Starvation: one queued result, W writes r1 every cycle
        drv(1, 1, 32'h1, 0, 0, 1, 20, 32'h2020, 0, 0);
        tick();
        for (int k = 1; k <= 9; k++) begin
            drv(1, 1, 32'(k), 0, 0, 0, 0, 0, 0, 0);
            chk($sformatf("starve_cyc%0d", k), 32'(starve), 32'(k == 9));
            tick();
        end
        idle();
        chk("starve_bubble_hold", 32'(starve), 1);
        chk("starve_bubble_addr", 32'(gpr_waddr), 20);
        chk("starve_bubble_data", gpr_wdata, 32'h2020);
        tick();
        chk("starve_cleared", 32'(starve), 0);

        // Reset mid-drain discards queued results and pending bits
        for (int k = 0; k < 3; k++) begin
            drv(1, 1, 32'h7, (k == 0), 2, 1, 5'(10 + k), 32'hB0 + 32'(k), 0, 0);
            tick();
        end
        drv(0, 0, 0, 0, 2, 0, 0, 0, 2, 0);
        chk("pre_rst_pending", pending, 32'h4);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_pending", pending, 0);
        chk("mid_rst_gpr_we", 32'(gpr_we), 0);
        chk("mid_rst_issue_ready", 32'(issue_ready), 1);
        chk("mid_rst_llu_ready", 32'(llu_ready), 1);
        chk("mid_rst_stall", 32'(stall_d), 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_gpr_we", 32'(gpr_we), 0);

        // Randomized traffic against the queue model
        do_reset();
        mq.delete(); infl.delete(); mpend = '0; mcnt = 0;
        for (int blk = 0; blk < 6; blk++) begin
            wprob = (blk % 3 == 0) ? 30 : (blk % 3 == 1) ? 70 : 97;
            for (int c = 0; c < 250; c++) begin
                wa = 5'($urandom_range(0, 31));
                if (mpend[wa]) wa = 5'd0;
                we = ($urandom_range(0, 99) < wprob);
                wd = $urandom;
                iv = 1'($urandom_range(0, 1));
                ia = 5'($urandom_range(0, 15));
                lv = (infl.size() > 0) && ($urandom_range(0, 99) < 60);
                la = lv ? infl[0] : 5'($urandom_range(0, 31));
                ld = $urandom;
                rs = 5'($urandom_range(0, 15));
                rt = 5'($urandom_range(0, 15));
                drv(we, wa, wd, iv, ia, lv, la, ld, rs, rt);

                wwr  = we && (wa != 0);
                mpop = !wwr && (mq.size() > 0);
                hd   = (mq.size() > 0) ? mq[0] : '{5'd0, 32'd0};
                e_we = wwr || (mpop && hd.a != 0);
                e_ir = (ia == 0) || !mpend[ia];
                mask = (mpop && hd.a != 0) ? (32'd1 << hd.a) : 32'd0;
                pe   = mpend & ~mask;
                e_st = ((rs != 0) && pe[rs]) || ((rt != 0) && pe[rt]);

                chk("rnd_gpr_we", 32'(gpr_we), 32'(e_we));
                if (e_we) begin
                    chk("rnd_waddr", 32'(gpr_waddr), 32'(wwr ? wa : hd.a));
                    chk("rnd_wdata", gpr_wdata, wwr ? wd : hd.d);
                end
                chk("rnd_llu_ready", 32'(llu_ready), 32'(mq.size() < DEPTH));
                chk("rnd_issue_ready", 32'(issue_ready), 32'(e_ir));
                chk("rnd_stall", 32'(stall_d), 32'(e_st));
                chk("rnd_pending", pending, mpend);
                chk("rnd_starve", 32'(starve), 32'(mcnt == LIM));

                if (mq.size() == 0 || mpop) mcnt = 0;
                else if (wwr && mcnt < LIM) mcnt++;
                if (lv && mq.size() < DEPTH) begin
                    mq.push_back('{la, ld});
                    void'(infl.pop_front());
                end
                if (mpop) begin
                    void'(mq.pop_front());
                    if (hd.a != 0) mpend[hd.a] = 1'b0;
                end
                if (iv && e_ir) begin
                    if (ia != 0) mpend[ia] = 1'b1;
                    infl.push_back(ia);
                end
                tick();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
